// File: rtl/mc_pkg.sv
// Shared constants, FSM state type and angle/LFSR helpers for the Monte-Carlo CORDIC sequencer.
package mc_pkg;

   localparam int          CORDIC_LATENCY = 34;
   localparam logic [7:0]  THETA_EXP      = 8'd126;
   localparam logic [31:0] LFSR_MASK      = 32'h8020_0003;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } mc_state_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

   // Exponent pinned to 126 keeps |theta| in [0.5,1) rad.
   function automatic logic [31:0] make_theta(input logic [31:0] s);
      return {s[31], THETA_EXP, s[22:0]};
   endfunction

endpackage

// File: rtl/mc_pair_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; push into a full FIFO is accepted when popping.
module mc_pair_fifo
#(
   parameter int DEPTH = 8,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/cordic_mc_sequencer.sv
// Issues credit-limited pseudo-random angles to the CORDIC pipe and pairs each with its cosine.
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | issuing angles while credit allows
// ST_DRAIN | all issued; waiting for in-flight results and FIFO to empty
// ST_DONE  | one-cycle done pulse
module cordic_mc_sequencer
   import mc_pkg::*;
#(
   parameter int LATENCY    = CORDIC_LATENCY,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic [5:0]       n_iter,
   input  logic [31:0]      seed,
   output logic             busy,
   output logic             done,
   output logic [31:0]      theta_out,
   output logic [5:0]       n_out,
   input  logic [31:0]      cordic_result,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_theta,
   output logic [31:0]      m_cos
);

   localparam int FCW = $clog2(FIFO_DEPTH) + 1;

   mc_state_t        state;
   mc_state_t        state_nxt;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] issued;
   logic [31:0]      lfsr;
   logic             start_ok;
   logic             issue;
   logic             issue_q;
   logic             tap;
   logic [LATENCY-1:0] vld_line;
   logic [31:0]      theta_line [LATENCY];
   logic [FCW-1:0]   inflight;
   logic [FCW-1:0]   fifo_count;
   logic             fifo_empty;
   logic             pop;
   logic [63:0]      head;

   assign start_ok = start && (state == ST_IDLE);
   // Credit counts results still in the pipe so the FIFO can never overflow.
   assign issue    = (state == ST_RUN) && (issued < num_q) &&
                     (int'(fifo_count) + int'(inflight) < FIFO_DEPTH);
   assign tap      = vld_line[LATENCY-1];
   assign pop      = m_valid && m_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = (num_samples == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (issued == num_q) state_nxt = ST_DRAIN;
         ST_DRAIN: if (inflight == '0 && fifo_empty) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ST_RUN, ST_DRAIN: busy = 1'b1;
         ST_DONE:          done = 1'b1;
         default:          ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr      <= 32'h1;
         num_q     <= '0;
         issued    <= '0;
         n_out     <= '0;
         theta_out <= '0;
         issue_q   <= 1'b0;
         inflight  <= '0;
      end else begin
         issue_q  <= issue;
         inflight <= inflight + FCW'(issue) - FCW'(tap);
         if (start_ok) begin
            lfsr   <= (seed == '0) ? 32'h1 : seed;
            num_q  <= num_samples;
            issued <= '0;
            n_out  <= n_iter;
         end else if (issue) begin
            theta_out <= make_theta(lfsr);
            lfsr      <= lfsr_step(lfsr);
            issued    <= issued + CNT_W'(1);
         end
      end
   end

   // issue_q marks the cycle theta_out is presented; the line ages it to the result cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_line <= '0;
      else        vld_line <= {vld_line[LATENCY-2:0], issue_q};
   end

   always_ff @(posedge clk) begin
      theta_line[0] <= theta_out;
      for (int i = 1; i < LATENCY; i++) theta_line[i] <= theta_line[i-1];
   end

   mc_pair_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (64)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (tap),
      .push_data ({theta_line[LATENCY-1], cordic_result}),
      .pop       (pop),
      .pop_data  (head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign m_valid = !fifo_empty;
   assign m_theta = head[63:32];
   assign m_cos   = head[31:0];

endmodule

// File: tb/tb_cordic_mc_sequencer.sv
// Directed bench for cordic_mc_sequencer with a fixed-latency behavioural CORDIC cosine model.
module tb_cordic_mc_sequencer;

   localparam int LAT = 34;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] num_samples = '0;
   logic [5:0]  n_iter = '0;
   logic [31:0] seed = '0;
   logic        busy, done, m_valid;
   logic        m_ready = 1'b1;
   logic [31:0] theta_out, cordic_result, m_theta, m_cos;
   logic [5:0]  n_out;

   cordic_mc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .num_samples   (num_samples),
      .n_iter        (n_iter),
      .seed          (seed),
      .busy          (busy),
      .done          (done),
      .theta_out     (theta_out),
      .n_out         (n_out),
      .cordic_result (cordic_result),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_theta       (m_theta),
      .m_cos         (m_cos)
   );

   always #5 clk = ~clk;

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) return 0.0;
      d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [7:0]  e;
      d = $realtobits(r);
      if (d[62:52] == 11'd0) return 32'h0;
      e = 8'(int'(d[62:52]) - 896);
      return {d[63], e, d[51:29]};
   endfunction

   function automatic logic [31:0] tb_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   function automatic logic [31:0] tb_theta(input logic [31:0] s);
      return {s[31], 8'd126, s[22:0]};
   endfunction

   // Behavioural CORDIC: samples theta_out each edge, result appears LAT cycles later.
   logic [31:0] cpipe [LAT];
   always @(posedge clk) begin
      cpipe[0] <= r2f($cos(f2r(theta_out)));
      for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
   end
   assign cordic_result = cpipe[LAT-1];

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   logic [31:0] exp_lfsr = 32'h1;
   logic [31:0] last_theta = '0;
   logic [31:0] cap_q [$];
   int iss_cnt = 0, acc_cnt = 0, done_cnt = 0, max_out = 0;
   bit busy_seen = 0;

   always @(negedge clk) begin
      if (!reset) begin
         last_theta = '0;
      end else begin
         if (theta_out != last_theta) begin
            iss_cnt++;
            last_theta = theta_out;
         end
         if (iss_cnt - acc_cnt > max_out) max_out = iss_cnt - acc_cnt;
         if (busy) busy_seen = 1;
         if (done) done_cnt++;
         if (m_valid && m_ready) begin
            chk("pair_theta", m_theta, tb_theta(exp_lfsr));
            chk("pair_cos", 64'((($cos(f2r(tb_theta(exp_lfsr))) - f2r(m_cos)) < 1e-6) &&
                                (($cos(f2r(tb_theta(exp_lfsr))) - f2r(m_cos)) > -1e-6)), 1);
            cap_q.push_back(m_theta);
            exp_lfsr = tb_step(exp_lfsr);
            acc_cnt++;
         end
      end
   end

   task automatic clear_stats(input logic [31:0] sd);
      exp_lfsr  = (sd == 32'h0) ? 32'h1 : sd;
      iss_cnt   = 0;
      acc_cnt   = 0;
      done_cnt  = 0;
      max_out   = 0;
      busy_seen = 0;
      cap_q.delete();
   endtask

   task automatic do_start(input logic [15:0] num, input logic [5:0] n, input logic [31:0] sd);
      @(posedge clk); #1;
      num_samples = num;
      n_iter      = n;
      seed        = sd;
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt != d0) return;
      end
      chk(tag, 0, 1);
   endtask

   logic [31:0] t1_tab [4];
   logic [31:0] hold_theta, hold_cos;
   int d0;

   initial begin
      t1_tab = '{32'h3F00_0001, 32'hBF20_0003, 32'hBF30_0002, 32'h3F18_0001};

      // Reset state
      repeat (3) @(posedge clk);
      #1 chk("reset_outs", {busy, done, m_valid, n_out, theta_out}, '0);
      reset = 1'b1;

      // Test 1: four samples from seed 1
      clear_stats(32'h1);
      do_start(16'd4, 6'd20, 32'h1);
      wait_done("t1_timeout", 400);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_pairs", acc_cnt, 4);
      chk("t1_done_pulses", done_cnt, 1);
      chk("t1_n_out", n_out, 20);
      for (int i = 0; i < 4; i++)
         if (i < cap_q.size()) chk("t1_theta_tab", cap_q[i], t1_tab[i]);

      // Test 2: zero samples
      clear_stats(32'h3);
      do_start(16'd0, 6'd9, 32'h3);
      chk("t2_done_now", done, 1);
      @(posedge clk); #1;
      chk("t2_done_gone", done, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("t2_busy_seen", busy_seen, 0);
      chk("t2_issues", iss_cnt, 0);
      chk("t2_mvalid", m_valid, 0);

      // Test 3: consumer stalled, credit limits issue to FIFO depth
      m_ready = 1'b0;
      clear_stats(32'h1234_5678);
      do_start(16'd100, 6'd12, 32'h1234_5678);
      repeat (80) @(posedge clk);
      #1;
      chk("t3_issues_stall", iss_cnt, 8);
      chk("t3_mvalid", m_valid, 1);
      chk("t3_head_theta", m_theta, tb_theta(32'h1234_5678));
      hold_theta = m_theta;
      hold_cos   = m_cos;
      repeat (20) @(posedge clk);
      #1;
      chk("t3_theta_stable", m_theta, hold_theta);
      chk("t3_cos_stable", m_cos, hold_cos);
      chk("t3_issues_still", iss_cnt, 8);
      m_ready = 1'b1;
      wait_done("t3_timeout", 3000);
      #1;
      chk("t3_pairs", acc_cnt, 100);
      chk("t3_max_outstanding", max_out, 8);

      // Test 4: m_ready toggling
      clear_stats(32'hDEAD_BEEF);
      do_start(16'd50, 6'd16, 32'hDEAD_BEEF);
      d0 = done_cnt;
      for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
         @(posedge clk); #1;
         m_ready = ~m_ready;
      end
      chk("t4_done_seen", 64'(done_cnt != d0), 1);
      m_ready = 1'b1;
      chk("t4_pairs", acc_cnt, 50);
      chk("t4_credit_ok", 64'(max_out <= 8), 1);

      // Test 5: reset mid-run, then restart with seed 0
      clear_stats(32'h0000_ACE1);
      do_start(16'd40, 6'd5, 32'h0000_ACE1);
      for (int i = 0; i < 500 && iss_cnt < 10; i++) @(negedge clk);
      chk("t5_reached_10", 64'(iss_cnt >= 10), 1);
      reset = 1'b0;
      #1 chk("t5_abort_outs", {busy, done, m_valid, n_out, theta_out}, '0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chk("t5_no_done", done_cnt, 0);
      chk("t5_idle", {busy, m_valid}, 0);
      clear_stats(32'h0);
      do_start(16'd4, 6'd20, 32'h0);
      wait_done("t5_timeout", 400);
      #1;
      chk("t5_pairs", acc_cnt, 4);
      for (int i = 0; i < 4; i++)
         if (i < cap_q.size()) chk("t5_theta_tab", cap_q[i], t1_tab[i]);

      // Test 6: starts during a run are ignored; n_out latched
      clear_stats(32'h5);
      do_start(16'd30, 6'd20, 32'h5);
      repeat (3) begin
         @(posedge clk); #1;
         num_samples = 16'd3; n_iter = 6'd7; seed = 32'h9; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("t6_n_out_run", n_out, 20);
      chk("t6_busy_run", busy, 1);
      wait_done("t6_timeout", 1500);
      #1;
      chk("t6_pairs", acc_cnt, 30);
      chk("t6_done_pulses", done_cnt, 1);
      chk("t6_n_out_after", n_out, 20);

      // Start presented in the DONE cycle is dropped
      clear_stats(32'h5);
      do_start(16'd2, 6'd20, 32'h5);
      for (int i = 0; i < 400 && done !== 1'b1; i++) @(negedge clk);
      chk("t6_done_seen", done, 1);
      num_samples = 16'd5; n_iter = 6'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_done_start_busy", busy, 0);
      chk("t6_done_start_n", n_out, 20);
      chk("t6_done_start_pairs", acc_cnt, 2);
      do_start(16'd0, 6'd7, 32'h1);
      chk("t6_n_out_new", n_out, 7);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
